mips_multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational control path with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one memory port and one ALU. It adds a memory-ready handshake with a wait-state watchdog, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the shared datapath muxes, PC and register-file enables.

---
 rtl/mips_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle control unit for the MIPS core. It steps each instruction
// through fetch, decode, execute, memory and writeback, so the datapath
// needs only one memory port and one ALU.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode, funct     instruction fields from the instruction register
//   mem_ready         the shared memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source, arith, jreg
//                     datapath mux selects and write enables
//   state             current FSM state (debug)
//   illegal           sticky trap flag (illegal opcode or memory timeout)
//   instr_count       retired-instruction counter, wraps modulo 2^CNT_W
//
// Memory handshake: a request (mem_read or mem_write) is held for as long
// as the FSM stays in FETCH, MEM_RD or MEM_WR. The access completes on the
// first rising edge at which mem_ready=1, and the FSM then moves on. If
// mem_ready is still 0 after WAIT_MAX consecutive cycles in one of these
// wait states, the FSM traps.
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             arith,
  output logic             jreg,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_IMM_EX   = 4'd11,
    S_IMM_WB   = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;

  assign state  = state_q;
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == S_TRAP) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    arith         = 1'b0;
    jreg          = 1'b0;

    // Watchdog for the wait states. The counter holds the number of
    // consecutive low mem_ready cycles seen so far. The low cycle that
    // would make the count WAIT_MAX sends the FSM to TRAP. Every other
    // state leaves wait_d at its default of 0, so leaving a wait state
    // clears the counter.
    if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR)
        && !mem_ready) begin
      if (wait_q == WAIT_LAST) state_d = S_TRAP;
      else                     wait_d  = wait_q + 1'b1;
    end

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        arith     = 1'b1;
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_RTYPE:                 state_d = S_EXEC_R;
          OP_BEQ:                   state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_JAL:                   state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EX;
          default:                  state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        arith     = 1'b1;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        if (funct == FN_JR) begin
          // The jump target comes from rs, so no register is written.
          jreg      = 1'b1;
          pc_write  = 1'b1;
          pc_source = 2'b11;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        state_d    = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        // addi sign-extends its immediate; andi and ori zero-extend.
        arith     = (opcode == OP_ADDI);
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      // TRAP, plus the unused encodings, which also fall into TRAP.
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Instance a uses the default
// parameters. Instance b uses WAIT_MAX=4 and CNT_W=2 to reach the watchdog
// trap and the counter wrap quickly.
module tb_mips_multicycle_ctrl;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;
  logic [5:0] opcode, funct;
  logic mem_ready, mem_ready_b;

  // instance a outputs
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic reg_write, alu_src_a, arith, jreg, illegal;
  logic [3:0] state;
  logic [31:0] instr_count;

  // instance b outputs
  logic pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
  logic [1:0] reg_dst_b, mem_to_reg_b, alu_src_b_b, alu_op_b, pc_source_b;
  logic reg_write_b, alu_src_a_b, arith_b, jreg_b, illegal_b;
  logic [3:0] state_b;
  logic [1:0] instr_count_b;

  mips_multicycle_ctrl dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .arith(arith), .jreg(jreg), .state(state),
    .illegal(illegal), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.CNT_W(2), .WAIT_MAX(4), .WAIT_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode), .funct(funct), .mem_ready(mem_ready_b),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
    .pc_source(pc_source_b), .arith(arith_b), .jreg(jreg_b), .state(state_b),
    .illegal(illegal_b), .instr_count(instr_count_b)
  );

  int vectors = 0;
  int errors  = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one edge, then check the state instance a has moved to.
  task automatic step_a(input string tag, input logic [3:0] exp_state);
    tick();
    chk(tag, {28'd0, state}, {28'd0, exp_state});
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    opcode = 6'h00; funct = 6'h20;
    mem_ready = 1'b0; mem_ready_b = 1'b0;
    tick(); tick();

    // Reset values, with mem_ready low so FETCH drives only its fixed
    // controls.
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd1);
    chk("rst_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    rst = 1'b0;
    tick();
    chk("fetch_hold", {28'd0, state}, 32'd0);

    // R-type add: states 0,1,6,7,0
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_write", {31'd0, ir_write}, 32'd1);
    chk("fetch_pc_write", {31'd0, pc_write}, 32'd1);
    step_a("add_decode", 4'd1);
    chk("decode_alu_src_b", {30'd0, alu_src_b}, 32'd3);
    chk("decode_arith", {31'd0, arith}, 32'd1);
    step_a("add_exec", 4'd6);
    chk("exec_alu_op", {30'd0, alu_op}, 32'd2);
    chk("exec_reg_write", {31'd0, reg_write}, 32'd0);
    step_a("add_wb", 4'd7);
    chk("wb_r_reg_write", {31'd0, reg_write}, 32'd1);
    chk("wb_r_reg_dst", {30'd0, reg_dst}, 32'd1);
    step_a("add_done", 4'd0);
    chk("add_count", instr_count, 32'd1);

    // lw with mem_ready low for 3 cycles in MEM_RD
    opcode = 6'h23;
    step_a("lw_decode", 4'd1);
    step_a("lw_addr", 4'd2);
    chk("lw_addr_alu_src_b", {30'd0, alu_src_b}, 32'd2);
    mem_ready = 1'b0;
    step_a("lw_rd", 4'd3);
    chk("lw_rd_i_or_d", {31'd0, i_or_d}, 32'd1);
    chk("lw_rd_mem_read", {31'd0, mem_read}, 32'd1);
    for (int i = 0; i < 3; i++) step_a("lw_rd_wait", 4'd3);
    mem_ready = 1'b1;
    step_a("lw_wb", 4'd4);
    chk("wb_mem_mem_to_reg", {30'd0, mem_to_reg}, 32'd1);
    chk("wb_mem_reg_write", {31'd0, reg_write}, 32'd1);
    step_a("lw_done", 4'd0);
    chk("lw_count", instr_count, 32'd2);

    // sw
    opcode = 6'h2B;
    step_a("sw_decode", 4'd1);
    step_a("sw_addr", 4'd2);
    step_a("sw_wr", 4'd5);
    chk("sw_mem_write", {31'd0, mem_write}, 32'd1);
    chk("sw_i_or_d", {31'd0, i_or_d}, 32'd1);
    step_a("sw_done", 4'd0);

    // beq
    opcode = 6'h04;
    step_a("beq_decode", 4'd1);
    step_a("beq_exec", 4'd8);
    chk("beq_pc_write_cond", {31'd0, pc_write_cond}, 32'd1);
    chk("beq_pc_source", {30'd0, pc_source}, 32'd1);
    chk("beq_alu_op", {30'd0, alu_op}, 32'd1);
    step_a("beq_done", 4'd0);

    // j
    opcode = 6'h02;
    step_a("j_decode", 4'd1);
    step_a("j_exec", 4'd9);
    chk("j_pc_source", {30'd0, pc_source}, 32'd2);
    chk("j_pc_write", {31'd0, pc_write}, 32'd1);
    step_a("j_done", 4'd0);

    // jal
    opcode = 6'h03;
    step_a("jal_decode", 4'd1);
    step_a("jal_exec", 4'd10);
    chk("jal_reg_dst", {30'd0, reg_dst}, 32'd2);
    chk("jal_mem_to_reg", {30'd0, mem_to_reg}, 32'd2);
    chk("jal_reg_write", {31'd0, reg_write}, 32'd1);
    step_a("jal_done", 4'd0);

    // jr
    opcode = 6'h00; funct = 6'h08;
    step_a("jr_decode", 4'd1);
    step_a("jr_exec", 4'd6);
    chk("jr_jreg", {31'd0, jreg}, 32'd1);
    chk("jr_pc_source", {30'd0, pc_source}, 32'd3);
    chk("jr_reg_write", {31'd0, reg_write}, 32'd0);
    step_a("jr_done", 4'd0);
    chk("jr_count", instr_count, 32'd7);

    // andi, then addi
    opcode = 6'h0C;
    step_a("andi_decode", 4'd1);
    step_a("andi_ex", 4'd11);
    chk("andi_arith", {31'd0, arith}, 32'd0);
    chk("andi_alu_op", {30'd0, alu_op}, 32'd3);
    step_a("andi_wb", 4'd12);
    chk("imm_wb_reg_write", {31'd0, reg_write}, 32'd1);
    chk("imm_wb_reg_dst", {30'd0, reg_dst}, 32'd0);
    step_a("andi_done", 4'd0);
    opcode = 6'h08;
    step_a("addi_decode", 4'd1);
    step_a("addi_ex", 4'd11);
    chk("addi_arith", {31'd0, arith}, 32'd1);
    step_a("addi_wb", 4'd12);
    step_a("addi_done", 4'd0);
    chk("imm_count", instr_count, 32'd9);

    // Illegal opcode traps and stays trapped for 20 cycles.
    opcode = 6'h3F;
    step_a("ill_decode", 4'd1);
    step_a("ill_trap", 4'd15);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("trap_held", {28'd0, state}, 32'd15);
    chk("trap_mem_read", {31'd0, mem_read}, 32'd0);
    chk("trap_count", instr_count, 32'd9);

    // Reset asserted between edges takes effect immediately.
    rst = 1'b1;
    #1;
    chk("rst2_state", {28'd0, state}, 32'd0);
    chk("rst2_illegal", {31'd0, illegal}, 32'd0);
    chk("rst2_count", instr_count, 32'd0);

    // Instance b: five 3-cycle jumps make the 2-bit counter wrap to 1.
    opcode = 6'h02;
    mem_ready_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(); tick(); tick();
      if (n == 4) chk("b_wrap_zero", {30'd0, instr_count_b}, 32'd0);
    end
    chk("b_wrap_count", {30'd0, instr_count_b}, 32'd1);
    chk("b_in_fetch", {28'd0, state_b}, 32'd0);

    // Watchdog: the 4th consecutive low mem_ready cycle in FETCH traps.
    mem_ready_b = 1'b0;
    tick(); tick(); tick();
    chk("b_wait3_state", {28'd0, state_b}, 32'd0);
    chk("b_wait3_illegal", {31'd0, illegal_b}, 32'd0);
    tick();
    chk("b_wd_trap", {28'd0, state_b}, 32'd15);
    chk("b_wd_illegal", {31'd0, illegal_b}, 32'd1);
    mem_ready_b = 1'b1;
    tick();
    chk("b_trap_absorb", {28'd0, state_b}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
